// File: rtl/mat_result_drain.sv
// Holding buffer for one packed N x N matrix-multiply result, streamed out one
// element per valid/ready handshake with row/column/last tags.
module mat_result_drain #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*N*DATA_W-1:0] d_in,
    input  logic                  d_valid,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drop_err,
    input  logic                  drop_clr
);

    localparam int WORDS = N * N;
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        idx;
    logic [WORDS*DATA_W-1:0] buffer;
    logic [DATA_W-1:0]       elems [WORDS];
    logic                    draining;
    logic                    handshake;
    logic                    load;
    logic                    drop;

    // Element 0 ([0][0]) sits in the most significant word of the packed result.
    for (genvar i = 0; i < WORDS; i++) begin : g_elem
        assign elems[i] = buffer[(WORDS-1-i)*DATA_W +: DATA_W];
    end

    assign draining  = (state == DRAIN);
    assign out_valid = draining;
    assign busy      = draining;
    assign out_data  = draining ? elems[idx] : '0;
    assign out_row   = draining ? IDX_W'(idx / CNT_W'(N)) : '0;
    assign out_col   = draining ? IDX_W'(idx % CNT_W'(N)) : '0;
    assign out_last  = draining && (idx == CNT_W'(WORDS - 1));
    assign handshake = out_valid && out_ready;

    // Gating with reset keeps the input closed while the block is held in reset.
    assign d_ready = reset && ((state == IDLE) || (out_last && out_ready));
    assign load    = d_valid && d_ready;
    assign drop    = d_valid && !d_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = DRAIN;
            DRAIN:   if (handshake && out_last && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            buffer   <= '0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_next;
            drop_err <= drop || (drop_err && !drop_clr);
            if (load) begin
                buffer <= d_in;
                idx    <= '0;
            end else if (handshake && !out_last) begin
                idx <= idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mat_result_drain.sv
// Directed and randomized checks of mat_result_drain against a queue model of
// pending elements.
module tb_mat_result_drain;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 2;
    localparam int WORDS  = N * N;
    localparam int DW     = WORDS * DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DW-1:0]     d_in = '0;
    logic              d_valid = 1'b0;
    logic              d_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;
    logic              out_last;
    logic              busy;
    logic              drop_err;
    logic              drop_clr = 1'b0;

    mat_result_drain #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .drop_err  (drop_err),
        .drop_clr  (drop_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
        logic              last;
    } elem_t;

    elem_t q[$];
    logic  m_err = 1'b0;
    int    hs_count = 0;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return reset && ((q.size() == 0) || (q.size() == 1 && out_ready));
    endfunction

    task automatic push_result(input logic [DW-1:0] v);
        elem_t e;
        for (int i = 0; i < WORDS; i++) begin
            e.data = v[DW-1-DATA_W*i -: DATA_W];
            e.row  = IDX_W'(i / N);
            e.col  = IDX_W'(i % N);
            e.last = (i == WORDS - 1);
            q.push_back(e);
        end
    endtask

    function automatic logic [DW-1:0] seq_result(input logic [DATA_W-1:0] base);
        logic [DW-1:0] v;
        for (int i = 0; i < WORDS; i++) v[DW-1-DATA_W*i -: DATA_W] = base + DATA_W'(i);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_result();
        logic [DW-1:0] v;
        for (int i = 0; i < WORDS; i++) v[DATA_W*i +: DATA_W] = $urandom;
        return v;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("d_ready", d_ready, m_ready());
        chk("drop_err", drop_err, m_err);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_row", out_row, q[0].row);
            chk("out_col", out_col, q[0].col);
            chk("out_last", out_last, q[0].last);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_d_ready", d_ready, 0);
    endtask

    // Inputs are already applied; check, clock, then advance the model.
    task automatic cycle();
        logic rdy;
        logic hs;
        #3;
        check_outputs();
        rdy = m_ready();
        hs  = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (reset) begin
            if (hs) begin
                void'(q.pop_front());
                hs_count++;
            end
            if (d_valid && rdy) push_result(d_in);
            m_err = (d_valid && !rdy) || (m_err && !drop_clr);
        end
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        d_valid = 1'b0;
        while (q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        #3;
        chk("drain_timeout", out_valid, 0);
    endtask

    task automatic load(input logic [DW-1:0] v);
        d_in = v;
        d_valid = 1'b1;
        cycle();
        d_valid = 1'b0;
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            d_in = rand_result();
            d_valid = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            drop_clr = $urandom_range(0, 1);
            @(negedge clk);
            check_reset_state();
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        d_valid = 1'b0;
        drop_clr = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Single result, full-rate drain
        load(seq_result(32'h0));
        #3;
        chk("first_elem", out_data, 32'h0);
        #0;
        drain(40);

        // Backpressure pattern 1,0,0,1,0,0...
        load(seq_result(32'h0));
        hs_count = 0;
        for (int n = 0; n < 80 && q.size() != 0; n++) begin
            out_ready = (n % 3 == 0);
            cycle();
        end
        chk("bp_handshakes", hs_count, 16);
        out_ready = 1'b1;
        drain(20);

        // Back-to-back results with no bubble
        load(seq_result(32'h0));
        for (int n = 0; n < 40 && q.size() > 1; n++) cycle();
        d_in = seq_result(32'hA0);
        d_valid = 1'b1;
        cycle();
        d_valid = 1'b0;
        #3;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_first", out_data, 32'hA0);
        drain(40);

        // Offer while busy sets drop_err without disturbing the stream
        load(rand_result());
        for (int n = 0; n < 20 && q.size() > 11; n++) cycle();
        d_in = rand_result();
        d_valid = 1'b1;
        cycle();
        d_valid = 1'b0;
        #3;
        chk("drop_set", drop_err, 1);
        cycle();
        drop_clr = 1'b1;
        cycle();
        drop_clr = 1'b0;
        #3;
        chk("drop_cleared", drop_err, 0);
        drain(40);

        // Clear and new drop on the same cycle keeps the flag
        load(rand_result());
        d_in = rand_result();
        d_valid = 1'b1;
        drop_clr = 1'b1;
        cycle();
        d_valid = 1'b0;
        drop_clr = 1'b0;
        drain(40);

        // Reset in the middle of a drain
        load(rand_result());
        for (int n = 0; n < 20 && q.size() > 9; n++) cycle();
        reset = 1'b0;
        #1;
        check_reset_state();
        q.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
        load(seq_result(32'h100));
        #3;
        chk("post_reset_first", out_data, 32'h100);
        #0;
        drain(40);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            d_in = rand_result();
            d_valid = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drop_clr = ($urandom_range(0, 7) == 0);
            cycle();
        end
        d_valid = 1'b0;
        drop_clr = 1'b0;
        out_ready = 1'b1;
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
